// File: rtl/gpio_key_pkg.sv
// Shared types and constants for the GPIO key/interrupt controller.
// Pin map, FSM state encoding and default timing counts live here.
package gpio_key_pkg;

  localparam int PIN_W    = 3;
  localparam int NUM_KEYS = 2;

  localparam int INTR_BIT = 2;
  localparam int KEY1_BIT = 1;
  localparam int KEY0_BIT = 0;

  localparam int DEBOUNCE_CNT_DEF = 1000000;
  localparam int HOLDOFF_CNT_DEF  = 1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } intr_state_e;

  // Counter width able to hold terminal-1; never narrower than one bit.
  function automatic int cnt_width(input int terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/gpio_key_if.sv
// Software-facing control/status bundle of the key controller.
// master = register/software side, slave = controller side.
interface gpio_key_if;

  logic                               intr_en;
  logic                               intr_ack;
  logic [gpio_key_pkg::NUM_KEYS-1:0]  evt_clr;
  logic [gpio_key_pkg::NUM_KEYS-1:0]  key_state;
  logic [gpio_key_pkg::NUM_KEYS-1:0]  key_evt;
  logic                               intr_busy;

  modport master (
    output intr_en,
    output intr_ack,
    output evt_clr,
    input  key_state,
    input  key_evt,
    input  intr_busy
  );

  modport slave (
    input  intr_en,
    input  intr_ack,
    input  evt_clr,
    output key_state,
    output key_evt,
    output intr_busy
  );

endinterface

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, stability counter and debounced level.
// A level is accepted only after it differs from key_level for DEBOUNCE_CNT cycles.
module key_debounce
  import gpio_key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_async,
  output logic key_level
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic             sync_0_reg;
  logic             sync_1_reg;
  logic             key_level_reg;
  logic             key_level_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Idle (released) level is 1, so the synchronizer resets to 1 as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_0_reg    <= 1'b1;
      sync_1_reg    <= 1'b1;
      key_level_reg <= 1'b1;
      cnt_reg       <= '0;
    end else begin
      sync_0_reg    <= pad_async;
      sync_1_reg    <= sync_0_reg;
      key_level_reg <= key_level_next;
      cnt_reg       <= cnt_next;
    end
  end

  always_comb begin
    key_level_next = key_level_reg;
    cnt_next       = '0;
    if (sync_1_reg != key_level_reg) begin
      if (cnt_reg >= CNT_LAST) begin
        key_level_next = sync_1_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  assign key_level = key_level_reg;

endmodule

// File: rtl/gpio_key_ctrl.sv
// Two debounced keys with sticky press flags driving an open-drain interrupt pin.
// The pin is pulled low in ASSERT and held released for HOLDOFF_CNT cycles after release.
module gpio_key_ctrl
  import gpio_key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int HOLDOFF_CNT  = HOLDOFF_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [PIN_W-1:0] gpio_t,
  output logic [PIN_W-1:0] gpio_o,
  input  logic [PIN_W-1:0] gpio_i,
  gpio_key_if.slave        bus
);

  localparam int              HOLD_W    = cnt_width(HOLDOFF_CNT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CNT - 1);

  logic [NUM_KEYS-1:0] key_state_w;
  logic [NUM_KEYS-1:0] key_prev_reg;
  logic [NUM_KEYS-1:0] key_evt_reg;
  logic [NUM_KEYS-1:0] key_evt_next;
  logic [NUM_KEYS-1:0] key_fall;

  intr_state_e         state_reg;
  intr_state_e         state_next;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic [HOLD_W-1:0]   hold_cnt_next;
  logic                pin_release_reg;
  logic                pin_release_next;

  // The interrupt pad readback carries nothing useful for the controller.
  logic                intr_pad_unused;
  assign intr_pad_unused = gpio_i[INTR_BIT];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
      ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .pad_async (gpio_i[KEY0_BIT + gi]),
        .key_level (key_state_w[gi])
      );
    end
  endgenerate

  // Active-low keys: a press is a 1->0 step of the debounced level.
  assign key_fall     = key_prev_reg & ~key_state_w;
  assign key_evt_next = (key_evt_reg & ~bus.evt_clr) | key_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev_reg    <= '1;
      key_evt_reg     <= '0;
      state_reg       <= IDLE;
      hold_cnt_reg    <= '0;
      pin_release_reg <= 1'b1;
    end else begin
      key_prev_reg    <= key_state_w;
      key_evt_reg     <= key_evt_next;
      state_reg       <= state_next;
      hold_cnt_reg    <= hold_cnt_next;
      pin_release_reg <= pin_release_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = '0;
    unique case (state_reg)
      IDLE: begin
        if (bus.intr_en && (|key_evt_reg)) begin
          state_next = ASSERT;
        end
      end
      ASSERT: begin
        if (bus.intr_ack || !bus.intr_en) begin
          state_next = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (hold_cnt_reg >= HOLD_LAST) begin
          state_next = IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Pad control comes from its own flop so the output never sees decode glitches.
    pin_release_next = (state_next != ASSERT);
  end

  always_comb begin
    gpio_t           = '1;
    gpio_o           = '0;
    gpio_t[INTR_BIT] = pin_release_reg;
  end

  assign bus.key_state = key_state_w;
  assign bus.key_evt   = key_evt_reg;
  assign bus.intr_busy = (state_reg != IDLE);

endmodule

// File: doc/gpio_key_ctrl.md
GPIO_KEY_CTRL -- requirements
Module: gpio_key_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 1000000; cycles a synchronized key level must hold before it is accepted (20 ms at 50 MHz).
REQ-002 Parameter HOLDOFF_CNT, default 1000; cycles the interrupt pin stays released after acknowledge before it can re-assert.
REQ-003 Pin map fixed: bit 2 = interrupt pin, bit 1 = key_1, bit 0 = key_0; pin bus width is 3.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 gpio_t  output  3  IOBUF tri-state controls, 1 = high-Z.
REQ-007 gpio_o  output  3  IOBUF drive values.
REQ-008 gpio_i  input  3  IOBUF pad readback, asynchronous to clk.
REQ-009 intr_en  input  1  interrupt enable, level.
REQ-010 intr_ack  input  1  single-cycle acknowledge pulse from software.
REQ-011 evt_clr  input  2  per-key write-1-to-clear pulses for key_evt.
REQ-012 key_state  output  2  debounced key levels, active-low (0 = pressed).
REQ-013 key_evt  output  2  sticky press-event flags.
REQ-014 intr_busy  output  1  high while the FSM is not in IDLE.

Function
REQ-015 gpio_t[1:0] SHALL be constant 1 and gpio_o[1:0] constant 0; key pins are never driven.
REQ-016 The interrupt pin SHALL be open-drain: gpio_o[2] constant 0; gpio_t[2] = 0 only in state ASSERT, else 1.
REQ-017 gpio_i[1:0] SHALL pass through a 2-flop synchronizer before any use; gpio_i[2] is ignored.
REQ-018 Per key, a counter of width clog2(DEBOUNCE_CNT) SHALL clear whenever synchronized level equals key_state, otherwise increment; at DEBOUNCE_CNT-1 key_state takes the synchronized level and the counter clears.
REQ-019 A 1->0 transition of key_state[n] SHALL set key_evt[n] on the following cycle; 0->1 transitions set nothing.
REQ-020 evt_clr[n] SHALL clear key_evt[n] next cycle; a simultaneous set wins (flag stays 1).
REQ-021 FSM states IDLE, ASSERT, HOLDOFF; encodings in the shared package.
REQ-022 IDLE -> ASSERT when intr_en = 1 and |key_evt = 1; pin pulls low the cycle after entry condition is sampled.
REQ-023 ASSERT -> HOLDOFF on intr_ack = 1 or intr_en = 0; ack and intr_en drop in the same cycle SHALL behave identically.
REQ-024 HOLDOFF SHALL count HOLDOFF_CNT cycles with pin released, then return to IDLE; a new assertion is possible only from IDLE.
REQ-025 intr_ack outside ASSERT SHALL be ignored.
REQ-026 Events arriving during ASSERT or HOLDOFF SHALL stay latched and re-trigger from IDLE if still set.
REQ-027 Counters SHALL saturate/clear as stated; no wrap-around beyond their terminal counts.

Reset
REQ-028 On rst_n = 0, asynchronously: gpio_t = 3'b111, gpio_o = 3'b000, key_state = 2'b11, key_evt = 2'b00, intr_busy = 0, FSM = IDLE, synchronizers = 1, all counters = 0.
REQ-029 Reset mid-ASSERT SHALL release the pin immediately and discard pending events.
REQ-030 After rst_n deasserts, a key already held low SHALL register one press only after DEBOUNCE_CNT stable cycles.

Structure
REQ-031 FSM state typedef, pin-index constants (INTR_BIT=2, KEY1_BIT=1, KEY0_BIT=0) and default counts SHALL live in package gpio_key_pkg.
REQ-032 One sub-module, key_debounce (synchronizer + counter + key_state register for one key), SHALL be instantiated twice.

Verification (DEBOUNCE_CNT=8, HOLDOFF_CNT=4)
REQ-033 Reset with gpio_i=3'b111 -> gpio_t=3'b111, key_state=2'b11, key_evt=0, intr_busy=0.
REQ-034 gpio_i[0] low with 3-cycle glitches repeated -> key_state[0] stays 1, no event, pin stays high-Z.
REQ-035 gpio_i[0] held low, intr_en=1 -> key_state[0]=0 after 2+8 cycles, key_evt=2'b01 next cycle, gpio_t[2]=0 one cycle later.
REQ-036 intr_ack in ASSERT -> gpio_t[2]=1 next cycle, intr_busy high 4 more cycles; key_evt still 2'b01 -> re-asserts; evt_clr=2'b01 in HOLDOFF -> stays IDLE.
REQ-037 evt_clr[1] coincident with key_1 press-set -> key_evt[1]=1.
REQ-038 rst_n low during ASSERT -> gpio_t=3'b111 without clock edge, key_evt=0.
